// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq
// -------------------
// AES InvMixColumns for the decrypt round loop. A 128-bit state is captured on
// a start request and transformed one column per clock through a single shared
// GF(2^8) column multiplier. The finished state is published in one step
// together with a one-cycle done pulse.
//
// Handshake: enable is a start request that is only looked at while IDLE; the
// edge that sees enable=1 in IDLE captures state. enable while busy is
// ignored. done pulses for exactly one cycle and state_out is valid from that
// cycle until the next done; there is no back-pressure.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   enable     start request (sampled only in IDLE)
//   state      input state, byte (row r, col c) at [(15-(4c+r))*8 +: 8]
//   state_out  transformed state, held between completions
//   done       one-cycle completion pulse
//   busy       high while a transform is running
module inv_mix_columns_seq #(
    parameter int word_size  = 8,
    parameter int array_size = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [word_size*array_size-1:0]   state,
    output logic [word_size*array_size-1:0]   state_out,
    output logic                              done,
    output logic                              busy
);

    localparam int state_w = word_size * array_size;
    localparam int col_w   = 4 * word_size;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // fsm_state is the observable controller state for checkers.
    fsm_state_t           fsm_state;
    fsm_state_t           fsm_next;
    logic [1:0]           col_cnt;
    logic [state_w-1:0]   in_reg;
    logic [state_w-1:0]   acc_reg;
    logic [state_w-1:0]   acc_next;
    logic [col_w-1:0]     col_in;
    logic [col_w-1:0]     col_out;
    logic                 capture;
    logic                 step;
    logic                 last;

    // Multiply by x modulo x^8+x^4+x^3+x+1; result always stays 8 bits.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns. The four constants 09/0b/0d/0e are all
    // built from the same x2/x4/x8 chain per input byte.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_state <= IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_next = fsm_state;
        case (fsm_state)
            IDLE:    if (enable) fsm_next = RUN;
            RUN:     if (col_cnt == 2'd3) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Control strobes derived from the current state.
    always_comb begin
        capture = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        case (fsm_state)
            IDLE: capture = enable;
            RUN: begin
                step = 1'b1;
                last = (col_cnt == 2'd3);
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Column 0 sits in the most significant 32 bits.
    always_comb begin
        col_in = '0;
        case (col_cnt)
            2'd0: col_in = in_reg[4*col_w-1 -: col_w];
            2'd1: col_in = in_reg[3*col_w-1 -: col_w];
            2'd2: col_in = in_reg[2*col_w-1 -: col_w];
            2'd3: col_in = in_reg[1*col_w-1 -: col_w];
            default: ;
        endcase
    end

    assign col_out = inv_col(col_in);

    always_comb begin
        acc_next = acc_reg;
        case (col_cnt)
            2'd0: acc_next[4*col_w-1 -: col_w] = col_out;
            2'd1: acc_next[3*col_w-1 -: col_w] = col_out;
            2'd2: acc_next[2*col_w-1 -: col_w] = col_out;
            2'd3: acc_next[1*col_w-1 -: col_w] = col_out;
            default: ;
        endcase
    end

    // Datapath. state_out is loaded from acc_next on the last column so all
    // four columns appear together and no partial result is ever visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt   <= 2'd0;
            in_reg    <= '0;
            acc_reg   <= '0;
            state_out <= '0;
            done      <= 1'b0;
        end else begin
            done <= last;
            if (capture) begin
                in_reg  <= state;
                col_cnt <= 2'd0;
            end else if (step) begin
                acc_reg <= acc_next;
                col_cnt <= col_cnt + 2'd1;
                if (last) begin
                    state_out <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         done;
    logic         busy;

    int n_checks    = 0;
    int n_fail      = 0;
    int n_starts    = 0;
    int n_aborted   = 0;
    int done_total  = 0;

    inv_mix_columns_seq #(
        .word_size (8),
        .array_size(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .state    (state_in),
        .state_out(state_out),
        .done     (done),
        .busy     (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_total++;
    end

    // Hand-computed directed vectors.
    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V2_EXP = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V3_IN  = 128'h4d7ebdf8_d5d5d7d6_00000000_00000000;
    localparam logic [127:0] V3_EXP = 128'h2d26314c_d4d4d4d5_00000000_00000000;

    // Encrypt-side MixColumns, used to build round-trip stimulus.
    function automatic logic [7:0] xt(input logic [7:0] a);
        xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix_col = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s);
        mix_state = {mix_col(s[127:96]), mix_col(s[95:64]),
                     mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    // Scoreboard check
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [127:0] s);
        state_in = s;
        enable   = 1'b1;
        tick();
        enable   = 1'b0;
        n_starts++;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done timeout observed=no_done expected=done");
        end
    endtask

    int cyc;
    int pulses;
    logic [127:0] rnd;
    logic [127:0] last_out;

    initial begin
        rst      = 1'b0;
        enable   = 1'b0;
        state_in = '0;
        #12;
        check("reset_state_out", state_out, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        rst = 1'b1;
        tick();

        // FIPS-197 single column set, with latency and busy checks.
        start_op(V1_IN);
        check("v1_busy_after_capture", {127'd0, busy}, 128'd1);
        check("v1_state_out_held", state_out, 128'd0);
        wait_done(cyc);
        check("v1_latency", 128'(cyc), 128'd4);
        check("v1_result", state_out, V1_EXP);
        check("v1_busy_at_done", {127'd0, busy}, 128'd0);
        tick();
        check("v1_done_one_cycle", {127'd0, done}, 128'd0);
        check("v1_state_out_stable", state_out, V1_EXP);

        // Reset mid-run (after E2) aborts; no done follows.
        start_op(V2_IN);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_state_out", state_out, 128'd0);
        check("rst_mid_done", {127'd0, done}, 128'd0);
        check("rst_mid_busy", {127'd0, busy}, 128'd0);
        n_aborted++;
        tick();
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) pulses++;
        end
        check("rst_no_done", 128'(pulses), 128'd0);

        // FIPS-197 App. B round 1, then back-to-back start in its done cycle.
        start_op(V2_IN);
        wait_done(cyc);
        check("v2_latency", 128'(cyc), 128'd4);
        check("v2_result", state_out, V2_EXP);
        start_op(V3_IN);
        check("b2b_busy", {127'd0, busy}, 128'd1);
        check("b2b_state_out_not_cleared", state_out, V2_EXP);
        wait_done(cyc);
        check("b2b_done_spacing", 128'(cyc + 1), 128'd5);
        check("v3_result", state_out, V3_EXP);
        tick();

        // Change state and pulse enable while running (at E2).
        start_op(V3_IN);
        tick();
        state_in = V1_IN;
        enable   = 1'b1;
        tick();
        enable   = 1'b0;
        pulses   = 0;
        last_out = '0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                last_out = state_out;
            end
            tick();
        end
        check("ignore_single_done", 128'(pulses), 128'd1);
        check("ignore_result", last_out, V3_EXP);
        check("ignore_state_out_held", state_out, V3_EXP);

        // Round trip through encrypt-side MixColumns.
        for (int k = 0; k < 100; k++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_op(mix_state(rnd));
            wait_done(cyc);
            check("round_trip", state_out, rnd);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        tick();
        check("done_count", 128'(done_total), 128'(n_starts - n_aborted));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
AES InvMixColumns stage for the decryption datapath; it inverts the MixColumns transform used on the encrypt side. It takes a 128-bit state and processes one column per clock, using a single shared GF(2^8) column multiplier. It raises a one-cycle done pulse when the whole state has been transformed. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round loop.

Parameters:
word_size, 8, byte width (fixed for AES; other values unsupported)
array_size, 16, bytes per state (fixed for AES)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
enable  input  1  start request; sampled only in IDLE
state  input  word_size*array_size  input state, sampled when the start is accepted
state_out  output  word_size*array_size  transformed state; held stable between dones
done  output  1  one-cycle pulse; state_out is valid from this cycle onward
busy  output  1  high while in RUN

Behaviour:
- Byte mapping: row r, column c occupies bits [(15-(4c+r))*8 +: 8].
  - So column 0 is state[127:96], and row 0 is the MSB byte of each column (FIPS-197 order).
- Column transform, with b = out, a = in:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - rows 1..3 use the same coefficients rotated right by one per row (row1: 09 0e 0b 0d, etc.).
  - Multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1 (0x11B).
  - Products are reduced to 8 bits; no wider intermediate leaks into the output.
- Reset (rst=0, async): FSM=IDLE, col_cnt=0, input/accumulator registers=0, state_out=0, done=0, busy=0.
  - Reset mid-RUN aborts the operation; no done is produced for it.
- FSM states: IDLE, RUN.
  - IDLE with enable=1 at edge E0: capture state into in_reg, col_cnt=0, go to RUN, busy=1.
  - RUN at edges E1..E4: transform column col_cnt of in_reg, write the result into acc_reg column col_cnt, then col_cnt++.
  - At E4 (col_cnt==3): state_out<=full result (all 128 bits at once; no partial column visible), done<=1 for exactly one cycle, busy<=0, col_cnt wraps to 0, go to IDLE.
- Latency: done is high in the cycle after E4, i.e. 4 clocks after the capture edge. Throughput is one state per 5 clocks.
- enable while in RUN is ignored. A change on state after capture has no effect.
- enable high during the done cycle: accepted at the next edge (FSM is already IDLE), giving back-to-back operation.
- enable held high continuously: the block restarts every 5 cycles on the current state value.
- state_out holds its last value until the next completion; it is not cleared at start.

Test Plan:
- Reset: drive rst=0 mid-run (after E2) -> state_out=0, done=0, busy=0 immediately; no done follows; next start completes normally.
- FIPS-197 single column: state=8e4da1bc 9fdc589d 01010101 c6c6c6c6, pulse enable -> busy for 4 cycles, done exactly 4 clocks after capture, state_out=db135345 f20a225c 01010101 c6c6c6c6.
- FIPS-197 App. B round 1: state=046681e5e0cb199a48f8d37a2806264c -> state_out=d4bf5d30e0b452aeb84111f11e2798e5.
- Busy/ignore: change state and pulse enable at E2 -> result is unchanged from the captured value; only one done pulse.
- Back-to-back: assert enable in the done cycle with state=4d7ebdf8 d5d5d7d6 (rest 0) -> second done 5 clocks after the first; state_out=2d26314c d4d4d4d5 00000000 00000000.
- Round trip: 100 random states through the encrypt-side MixColumns then this block -> output equals the original state every time; done count equals start count.
